pipeline_controller: RTL and testbench

Central stall/flush sequencer for the fetch, decode and execute pipeline. It drives the PC enable and the fetch-to-decode and decode-to-execute flip-flop enables. It also drives squash controls for load-use hazards, taken jumps/branches from the decode-stage jump/branch logic, and multi-cycle execute operations (M-extension divide). It keeps a performance counter of stall cycles and a sticky timeout error for multi-cycle operations.

---
 rtl/pipeline_controller.sv | 161 ++++++++++++++++
 tb/tb_pipeline_controller.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the fetch-decode-execute pipeline: load-use stalls,
// redirect squashes, multi-cycle execute waits, stall counter and timeout flag.
module pipeline_controller #(
    parameter int REGISTER_SIZE = 5,
    parameter int MC_TIMEOUT    = 80,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dec_valid,
    input  logic                     dec_rs1_used,
    input  logic                     dec_rs2_used,
    input  logic [REGISTER_SIZE-1:0] dec_rs1_addr,
    input  logic [REGISTER_SIZE-1:0] dec_rs2_addr,
    input  logic                     dec_redirect,
    input  logic                     dec_mc_start,
    input  logic                     ex_load,
    input  logic [REGISTER_SIZE-1:0] ex_rd_addr,
    input  logic                     ex_mc_done,
    output logic                     pc_enable,
    output logic                     f_to_d_enable_ff,
    output logic                     f_to_d_flush,
    output logic                     d_to_e_enable_ff,
    output logic                     d_to_e_bubble,
    output logic                     mc_busy,
    output logic                     mc_timeout_err,
    output logic [CNT_WIDTH-1:0]     stall_count
);

    localparam int MC_CNT_W = $clog2(MC_TIMEOUT + 1);
    localparam logic [MC_CNT_W-1:0] MC_LAST = MC_CNT_W'(MC_TIMEOUT - 1);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MC_WAIT = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_s;
    logic [MC_CNT_W-1:0]    mc_cnt_r;
    logic [CNT_WIDTH-1:0]   stall_count_r;
    logic                   mc_timeout_err_r;

    logic                   load_use_s;
    logic                   pc_en_s;
    logic                   f2d_en_s;
    logic                   f2d_flush_s;
    logic                   d2e_en_s;
    logic                   d2e_bubble_s;
    logic                   mc_enter_s;
    logic                   set_err_s;

    // Load-use hazard detection; x0 is never a real dependency
    always_comb begin
        load_use_s = dec_valid & ex_load & (ex_rd_addr != {REGISTER_SIZE{1'b0}}) &
                     ((dec_rs1_used & (dec_rs1_addr == ex_rd_addr)) |
                      (dec_rs2_used & (dec_rs2_addr == ex_rd_addr)));
    end

    // Next-state and pipeline control decode
    always_comb begin
        state_s      = state_r;
        pc_en_s      = 1'b1;
        f2d_en_s     = 1'b1;
        f2d_flush_s  = 1'b0;
        d2e_en_s     = 1'b1;
        d2e_bubble_s = 1'b0;
        mc_enter_s   = 1'b0;
        set_err_s    = 1'b0;
        case (state_r)
            RUN: begin
                if (load_use_s) begin
                    pc_en_s      = 1'b0;
                    f2d_en_s     = 1'b0;
                    d2e_bubble_s = 1'b1;
                end else if (dec_valid && dec_mc_start) begin
                    state_s    = MC_WAIT;
                    mc_enter_s = 1'b1;
                end else if (dec_valid && dec_redirect) begin
                    f2d_flush_s = 1'b1;
                end else begin
                    state_s = RUN;
                end
            end
            MC_WAIT: begin
                // Decode inputs are deliberately not looked at while waiting
                if (ex_mc_done) begin
                    state_s = RUN;
                end else if (mc_cnt_r == MC_LAST) begin
                    state_s   = RUN;
                    set_err_s = 1'b1;
                end else begin
                    pc_en_s  = 1'b0;
                    f2d_en_s = 1'b0;
                    d2e_en_s = 1'b0;
                end
            end
            default: begin
                state_s  = RUN;
                pc_en_s  = 1'b0;
                f2d_en_s = 1'b0;
                d2e_en_s = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Multi-cycle wait counter, restarted on every entry into MC_WAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mc_cnt_r <= {MC_CNT_W{1'b0}};
        end else if (mc_enter_s) begin
            mc_cnt_r <= {MC_CNT_W{1'b0}};
        end else if (state_r == MC_WAIT && mc_cnt_r != {MC_CNT_W{1'b1}}) begin
            mc_cnt_r <= mc_cnt_r + {{(MC_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            mc_cnt_r <= mc_cnt_r;
        end
    end

    // Saturating stall-cycle performance counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_r <= {CNT_WIDTH{1'b0}};
        end else if (!pc_en_s && stall_count_r != {CNT_WIDTH{1'b1}}) begin
            stall_count_r <= stall_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    // Sticky timeout error, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mc_timeout_err_r <= 1'b0;
        end else if (set_err_s) begin
            mc_timeout_err_r <= 1'b1;
        end else begin
            mc_timeout_err_r <= mc_timeout_err_r;
        end
    end

    // Control outputs respond in the same cycle but read as 0 while reset is held
    assign pc_enable        = pc_en_s & rst;
    assign f_to_d_enable_ff = f2d_en_s & rst;
    assign f_to_d_flush     = f2d_flush_s & rst;
    assign d_to_e_enable_ff = d2e_en_s & rst;
    assign d_to_e_bubble    = d2e_bubble_s & rst;
    assign mc_busy          = (state_r == MC_WAIT) & rst;
    assign mc_timeout_err   = mc_timeout_err_r;
    assign stall_count      = stall_count_r;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed self-checking bench for pipeline_controller with hand-computed
// expectations for hazards, redirects, multi-cycle waits, timeout and reset.
module tb_pipeline_controller;

    logic        clk;
    logic        rst;
    logic        dec_valid;
    logic        dec_rs1_used;
    logic        dec_rs2_used;
    logic [4:0]  dec_rs1_addr;
    logic [4:0]  dec_rs2_addr;
    logic        dec_redirect;
    logic        dec_mc_start;
    logic        ex_load;
    logic [4:0]  ex_rd_addr;
    logic        ex_mc_done;
    logic        pc_enable;
    logic        f_to_d_enable_ff;
    logic        f_to_d_flush;
    logic        d_to_e_enable_ff;
    logic        d_to_e_bubble;
    logic        mc_busy;
    logic        mc_timeout_err;
    logic [31:0] stall_count;

    int checks;
    int errors;

    pipeline_controller #(
        .REGISTER_SIZE(5),
        .MC_TIMEOUT(80),
        .CNT_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .dec_valid(dec_valid),
        .dec_rs1_used(dec_rs1_used),
        .dec_rs2_used(dec_rs2_used),
        .dec_rs1_addr(dec_rs1_addr),
        .dec_rs2_addr(dec_rs2_addr),
        .dec_redirect(dec_redirect),
        .dec_mc_start(dec_mc_start),
        .ex_load(ex_load),
        .ex_rd_addr(ex_rd_addr),
        .ex_mc_done(ex_mc_done),
        .pc_enable(pc_enable),
        .f_to_d_enable_ff(f_to_d_enable_ff),
        .f_to_d_flush(f_to_d_flush),
        .d_to_e_enable_ff(d_to_e_enable_ff),
        .d_to_e_bubble(d_to_e_bubble),
        .mc_busy(mc_busy),
        .mc_timeout_err(mc_timeout_err),
        .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dec_valid    = 1'b0;
        dec_rs1_used = 1'b0;
        dec_rs2_used = 1'b0;
        dec_rs1_addr = 5'd0;
        dec_rs2_addr = 5'd0;
        dec_redirect = 1'b0;
        dec_mc_start = 1'b0;
        ex_load      = 1'b0;
        ex_rd_addr   = 5'd0;
        ex_mc_done   = 1'b0;
    endtask

    task automatic check_ctrl(input string tag, input logic [4:0] exp);
        // exp = {pc_enable, f_to_d_enable_ff, f_to_d_flush, d_to_e_enable_ff, d_to_e_bubble}
        check(tag, {27'd0, pc_enable, f_to_d_enable_ff, f_to_d_flush, d_to_e_enable_ff, d_to_e_bubble},
              {27'd0, exp});
    endtask

    initial begin
        int pc_low;
        int busy_hi;
        checks = 0;
        errors = 0;
        idle_inputs();
        rst = 1'b0;

        repeat (2) tick();
        check_ctrl("reset_ctrl", 5'b00000);
        check("reset_busy", {31'd0, mc_busy}, 32'd0);
        check("reset_err", {31'd0, mc_timeout_err}, 32'd0);
        check("reset_stall", stall_count, 32'd0);

        rst = 1'b1;
        #1;
        check_ctrl("idle_ctrl", 5'b11010);
        tick();

        // Load-use on rs2
        dec_valid = 1'b1; dec_rs2_used = 1'b1; dec_rs2_addr = 5'd5;
        ex_load = 1'b1; ex_rd_addr = 5'd5;
        #1;
        check_ctrl("load_use_ctrl", 5'b10011 & 5'b00011);
        tick();
        check("load_use_stall", stall_count, 32'd1);
        ex_load = 1'b0;
        #1;
        check_ctrl("after_load_use", 5'b11010);

        // x0 destination and unused source never stall
        ex_load = 1'b1; ex_rd_addr = 5'd0; dec_rs1_used = 1'b1; dec_rs1_addr = 5'd0;
        dec_rs2_used = 1'b0;
        #1;
        check_ctrl("x0_no_stall", 5'b11010);
        tick();
        ex_rd_addr = 5'd7; dec_rs1_addr = 5'd7; dec_rs1_used = 1'b0;
        #1;
        check_ctrl("unused_rs1", 5'b11010);
        tick();
        check("no_stall_count", stall_count, 32'd1);

        // Bubble in decode suppresses the hazard
        dec_rs1_used = 1'b1; dec_valid = 1'b0;
        #1;
        check_ctrl("invalid_no_stall", 5'b11010);
        tick();

        // Redirect alone, then redirect overridden by load-use
        idle_inputs();
        dec_valid = 1'b1; dec_redirect = 1'b1;
        #1;
        check_ctrl("redirect", 5'b11110);
        tick();
        dec_redirect = 1'b0;
        #1;
        check_ctrl("redirect_done", 5'b11010);
        dec_redirect = 1'b1; ex_load = 1'b1; ex_rd_addr = 5'd3;
        dec_rs1_used = 1'b1; dec_rs1_addr = 5'd3;
        #1;
        check_ctrl("redirect_vs_lu", 5'b00011);
        tick();
        check("redirect_lu_stall", stall_count, 32'd2);

        // Divide: done arrives after 10 stalled MC_WAIT cycles
        idle_inputs();
        dec_valid = 1'b1; dec_mc_start = 1'b1; dec_redirect = 1'b1;
        #1;
        check_ctrl("mc_start_ctrl", 5'b11010);
        check("mc_start_busy", {31'd0, mc_busy}, 32'd0);
        tick();
        dec_mc_start = 1'b0;
        pc_low = 0;
        busy_hi = 0;
        // Decode keeps a redirect pending to show it is ignored during the wait
        for (int i = 0; i < 11; i++) begin
            ex_mc_done = (i == 10);
            #1;
            if (pc_enable == 1'b0) pc_low++;
            if (mc_busy == 1'b1) busy_hi++;
            if (i == 3) check_ctrl("mc_wait_ctrl", 5'b00000);
            if (i == 10) check_ctrl("mc_done_ctrl", 5'b11010);
            tick();
        end
        idle_inputs();
        #1;
        check("mc_pc_low", pc_low, 32'd10);
        check("mc_busy_cycles", busy_hi, 32'd11);
        check("mc_back_run", {31'd0, mc_busy}, 32'd0);
        check("mc_stall", stall_count, 32'd12);
        check_ctrl("mc_run_ctrl", 5'b11010);

        // Timeout: done never comes, 80th wait cycle releases and flags
        dec_valid = 1'b1; dec_mc_start = 1'b1;
        tick();
        idle_inputs();
        pc_low = 0;
        for (int i = 0; i < 80; i++) begin
            #1;
            if (pc_enable == 1'b0) pc_low++;
            if (i == 78) check("to_err_early", {31'd0, mc_timeout_err}, 32'd0);
            if (i == 79) check_ctrl("to_last_ctrl", 5'b11010);
            tick();
        end
        check("to_pc_low", pc_low, 32'd79);
        check("to_err_set", {31'd0, mc_timeout_err}, 32'd1);
        check("to_busy", {31'd0, mc_busy}, 32'd0);
        check("to_stall", stall_count, 32'd91);
        repeat (3) tick();
        check("to_err_sticky", {31'd0, mc_timeout_err}, 32'd1);

        // Reset pulse clears the sticky error
        rst = 1'b0;
        #1;
        check("to_err_cleared", {31'd0, mc_timeout_err}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Async reset in the middle of a wait
        dec_valid = 1'b1; dec_mc_start = 1'b1;
        tick();
        idle_inputs();
        tick();
        tick();
        check("pre_rst_busy", {31'd0, mc_busy}, 32'd1);
        check("pre_rst_stall", stall_count, 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check_ctrl("async_rst_ctrl", 5'b00000);
        check("async_rst_busy", {31'd0, mc_busy}, 32'd0);
        check("async_rst_stall", stall_count, 32'd0);
        tick();
        rst = 1'b1;
        #1;
        check_ctrl("post_rst_ctrl", 5'b11010);
        repeat (90) tick();
        check("post_rst_err", {31'd0, mc_timeout_err}, 32'd0);
        check("post_rst_busy", {31'd0, mc_busy}, 32'd0);
        check("post_rst_stall", stall_count, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
